// File: rtl/bcd_downcount_timer.sv
// Multi-digit BCD down-counter/timer with preset load, expiry pulse and optional
// periodic auto-reload. Borrows ripple digit-wise so Q always holds valid BCD.
module bcd_downcount_timer #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  zero,
  output logic                  busy,
  output logic                  done,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   q_r, q_s;
  logic [W-1:0]   preset_r, preset_s;
  logic           busy_r, done_r, done_s, load_err_r, load_err_s;

  function automatic logic is_bcd(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Borrow ripples from digit 0 upward; a 0 digit under borrow becomes 9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    logic [3:0]   d;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // Next-state, next-count and pulse generation with load taking priority over en.
  always_comb begin
    state_s    = state_r;
    q_s        = q_r;
    preset_s   = preset_r;
    done_s     = 1'b0;
    load_err_s = 1'b0;
    if (load) begin
      if (!is_bcd(load_val)) begin
        load_err_s = 1'b1;
      end else if (load_val == ZERO_V) begin
        q_s     = ZERO_V;
        state_s = IDLE;
      end else begin
        q_s      = load_val;
        preset_s = load_val;
        state_s  = RUN;
      end
    end else begin
      case (state_r)
        IDLE: begin
          q_s = q_r;
        end
        RUN: begin
          if (en) begin
            if (q_r == ONE_V) begin
              done_s = 1'b1;
              if (WRAP) begin
                q_s = preset_r;
              end else begin
                q_s     = ZERO_V;
                state_s = IDLE;
              end
            end else begin
              q_s = bcd_dec(q_r);
            end
          end else begin
            q_s = q_r;
          end
        end
        default: begin
          q_s     = ZERO_V;
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, count, preset and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      q_r        <= ZERO_V;
      preset_r   <= ZERO_V;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      q_r        <= q_s;
      preset_r   <= preset_s;
      busy_r     <= (state_s == RUN);
      done_r     <= done_s;
      load_err_r <= load_err_s;
    end
  end

  assign Q        = q_r;
  assign zero     = (q_r == ZERO_V);
  assign busy     = busy_r;
  assign done     = done_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_downcount_timer.sv
// Directed bench for bcd_downcount_timer: one-shot instance (u0) and periodic
// instance (u1), both 2 digits, checked against hand-computed values.
module tb_bcd_downcount_timer;

  logic       clk;
  logic       rst;
  logic       load0, en0, load1, en1;
  logic [7:0] lv0, lv1;
  logic [7:0] q0, q1;
  logic       zero0, busy0, done0, lerr0;
  logic       zero1, busy1, done1, lerr1;

  int n_checks;
  int n_pass;

  bcd_downcount_timer #(.DIGITS(2), .WRAP(1'b0)) u0 (
    .clk(clk), .rst(rst), .load(load0), .load_val(lv0), .en(en0),
    .Q(q0), .zero(zero0), .busy(busy0), .done(done0), .load_err(lerr0)
  );

  bcd_downcount_timer #(.DIGITS(2), .WRAP(1'b1)) u1 (
    .clk(clk), .rst(rst), .load(load1), .load_val(lv1), .en(en1),
    .Q(q1), .zero(zero1), .busy(busy1), .done(done1), .load_err(lerr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; load0 = 1'b0; en0 = 1'b0; lv0 = 8'h00;
    load1 = 1'b0; en1 = 1'b0; lv1 = 8'h00;

    // 1: reset
    step(); step();
    check("rst_q",    q0,    32'h00);
    check("rst_zero", zero0, 32'd1);
    check("rst_busy", busy0, 32'd0);
    check("rst_done", done0, 32'd0);
    check("rst_lerr", lerr0, 32'd0);
    check("rst_q1",   q1,    32'h00);
    rst = 1'b0;

    // 2: load 12, count down to 00
    load0 = 1'b1; lv0 = 8'h12;
    step();
    check("ld12_q",    q0,    32'h12);
    check("ld12_busy", busy0, 32'd1);
    check("ld12_zero", zero0, 32'd0);
    load0 = 1'b0; en0 = 1'b1;
    for (int k = 11; k >= 0; k--) begin
      step();
      exp_q = {4'(k / 10), 4'(k % 10)};
      check("dn_q",    q0,    32'(exp_q));
      check("dn_done", done0, 32'(k == 0));
      check("dn_busy", busy0, 32'(k != 0));
    end
    check("dn_zero", zero0, 32'd1);
    step();
    check("idle_q",    q0,    32'h00);
    check("idle_done", done0, 32'd0);

    // 3: hold when en=0, load beats en
    en0 = 1'b0; load0 = 1'b1; lv0 = 8'h20;
    step();
    load0 = 1'b0; en0 = 1'b1;
    step();
    check("q19", q0, 32'h19);
    en0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold19", q0, 32'h19);
    end
    load0 = 1'b1; en0 = 1'b1; lv0 = 8'h07;
    step();
    check("ld_en_q",    q0,    32'h07);
    check("ld_en_busy", busy0, 32'd1);

    // 4: invalid BCD load rejected
    en0 = 1'b0; lv0 = 8'h35;
    step();
    lv0 = 8'h1A;
    step();
    check("err_pulse", lerr0, 32'd1);
    check("err_q",     q0,    32'h35);
    check("err_busy",  busy0, 32'd1);
    load0 = 1'b0;
    step();
    check("err_clr", lerr0, 32'd0);
    check("err_q2",  q0,    32'h35);
    load0 = 1'b1; lv0 = 8'h00;
    step();
    check("ld0_q",    q0,    32'h00);
    check("ld0_busy", busy0, 32'd0);
    check("ld0_done", done0, 32'd0);
    lv0 = 8'hA1;
    step();
    check("errhi_pulse", lerr0, 32'd1);
    check("errhi_q",     q0,    32'h00);
    check("errhi_busy",  busy0, 32'd0);
    load0 = 1'b0;

    // 5: periodic reload on u1
    load1 = 1'b1; lv1 = 8'h03;
    step();
    check("w_ld_q", q1, 32'h03);
    load1 = 1'b0; en1 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_q = 8'(3 - (i % 3));
      check("w_q",    q1,    32'(exp_q));
      check("w_done", done1, 32'((i % 3) == 0));
      check("w_busy", busy1, 32'd1);
    end
    en1 = 1'b0;

    // 6: reset mid-count
    load0 = 1'b1; lv0 = 8'h50;
    step();
    load0 = 1'b0; en0 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("q45", q0, 32'h45);
    rst = 1'b1;
    step();
    check("mid_rst_q",    q0,    32'h00);
    check("mid_rst_busy", busy0, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_rst_q",    q0,    32'h00);
      check("post_rst_done", done0, 32'd0);
      check("post_rst_busy", busy0, 32'd0);
    end
    en0 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
